// File: rtl/hazard_unit.sv
// Hazard controller: M/W destination scoreboard, forwarding selects, stall/flush/freeze, memory-wait FSM.
// Latency: all controls combinational (0 cycles); scoreboard, FSM, counter and timeout update on clk.
// Backpressure: mem_req_m & !mem_ready_m freezes the whole pipeline; `HAZARD_FWD_EN selects forwarding vs full interlock.
module hazard_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       reg_write_e,
    input  logic       result_src_e,
    input  logic       pc_src_e,
    input  logic       mem_req_m,
    input  logic       mem_ready_m,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       freeze,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       mem_timeout,
    output logic       wait_state
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_rd_m;
    logic [4:0]    r_rd_w;
    logic          r_rw_m;
    logic          r_rw_w;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          r_timeout;
    logic          w_mem_wait;
    logic          w_hazard;

    assign w_mem_wait = mem_req_m & ~mem_ready_m;

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic rw_m,
                                           input logic [4:0] rd_w, input logic rw_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = 2'b10;
        else if (rw_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign w_hazard = result_src_e & reg_write_e & (rd_e != 5'd0)
                    & ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign forward_a_e = rst ? 2'b00 : fwd_sel(rs1_e, r_rd_m, r_rw_m, r_rd_w, r_rw_w);
    assign forward_b_e = rst ? 2'b00 : fwd_sel(rs2_e, r_rd_m, r_rw_m, r_rd_w, r_rw_w);
`else
    function automatic logic rd_hit(input logic [4:0] rd, input logic rw,
                                    input logic [4:0] rs1, input logic [4:0] rs2);
        return rw && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Without forwarding, any in-flight writer of a D-stage source must drain through W.
    assign w_hazard = rd_hit(rd_e,   reg_write_e, rs1_d, rs2_d)
                    | rd_hit(r_rd_m, r_rw_m,      rs1_d, rs2_d)
                    | rd_hit(r_rd_w, r_rw_w,      rs1_d, rs2_d);
    assign forward_a_e = 2'b00;
    assign forward_b_e = 2'b00;

    logic w_unused;
    assign w_unused = ^{result_src_e, rs1_e, rs2_e};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_m <= 5'd0;
            r_rw_m <= 1'b0;
            r_rd_w <= 5'd0;
            r_rw_w <= 1'b0;
        end else if (!freeze) begin
            r_rd_m <= rd_e;
            r_rw_m <= reg_write_e;
            r_rd_w <= r_rd_m;
            r_rw_w <= r_rw_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_mem_wait) w_state_nxt = ST_WAIT;
            ST_WAIT: if (mem_ready_m || !mem_req_m) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        freeze     = 1'b0;
        wait_state = (r_state == ST_WAIT);
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_mem_wait) begin
            freeze  = 1'b1;
            stall_f = 1'b1;
            stall_d = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (w_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Counter saturates so a stuck access keeps the timeout asserted without wrapping.
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_inc;
            if ((TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_MAX))
                r_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed test-plan sequences plus randomized traffic against a stage-list model.
module tb_hazard_unit;
    localparam int TMO = 4;
`ifdef HAZARD_FWD_EN
    localparam int FWD_M = 2;
    localparam int FWD_W = 1;
`else
    localparam int FWD_M = 0;
    localparam int FWD_W = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       reg_write_e, result_src_e, pc_src_e, mem_req_m, mem_ready_m;
    logic       stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout, wait_state;
    logic [1:0] forward_a_e, forward_b_e;

    always #5 clk = ~clk;

    hazard_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e), .pc_src_e(pc_src_e),
        .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .freeze(freeze), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .mem_timeout(mem_timeout), .wait_state(wait_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: index 0 = M stage, 1 = W stage; ws = in MEM_WAIT; run = completed wait cycles.
    int sb_rd[2] = '{0, 0};
    bit sb_rw[2] = '{0, 0};
    bit m_ws = 0, m_to = 0;
    int m_run = 0;
    bit chk_en = 0;

    function automatic int fsel(input int rs);
        for (int i = 0; i < 2; i++)
            if (sb_rw[i] && sb_rd[i] != 0 && sb_rd[i] == rs) return (i == 0) ? 2 : 1;
        return 0;
    endfunction

    task automatic idle();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0;
        reg_write_e = 0; result_src_e = 0; pc_src_e = 0; mem_req_m = 0; mem_ready_m = 0;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        idle();
    endtask

    task automatic eval();
        bit wc, haz, sf, sd, fd, fe, fz;
        int fa, fb;
        int ird[3];
        bit irw[3];
        #1;
        wc  = mem_req_m && !mem_ready_m;
        haz = 0;
`ifdef HAZARD_FWD_EN
        haz = result_src_e && reg_write_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        fa  = rst ? 0 : fsel(int'(rs1_e));
        fb  = rst ? 0 : fsel(int'(rs2_e));
`else
        ird = '{int'(rd_e), sb_rd[0], sb_rd[1]};
        irw = '{reg_write_e, sb_rw[0], sb_rw[1]};
        for (int i = 0; i < 3; i++)
            if (irw[i] && ird[i] != 0 && (ird[i] == rs1_d || ird[i] == rs2_d)) haz = 1;
        fa = 0;
        fb = 0;
`endif
        {sf, sd, fd, fe, fz} = 5'b0;
        if (rst)           begin fd = 1; fe = 1; end
        else if (wc)       begin fz = 1; sf = 1; sd = 1; end
        else if (pc_src_e) begin fd = 1; fe = 1; end
        else if (haz)      begin sf = 1; sd = 1; fe = 1; end
        if (chk_en) begin
            chk("m_stall_f", stall_f, sf);
            chk("m_stall_d", stall_d, sd);
            chk("m_flush_d", flush_d, fd);
            chk("m_flush_e", flush_e, fe);
            chk("m_freeze",  freeze,  fz);
            chk("m_fwd_a",   forward_a_e, fa);
            chk("m_fwd_b",   forward_b_e, fb);
            chk("m_wait_st", wait_state, m_ws);
            chk("m_timeout", mem_timeout, m_to);
        end
    endtask

    task automatic tick();
        bit wc;
        @(posedge clk);
        wc = mem_req_m && !mem_ready_m;
        if (rst) begin
            sb_rd = '{0, 0}; sb_rw = '{0, 0};
            m_ws = 0; m_run = 0; m_to = 0;
        end else begin
            if (!wc) begin
                sb_rd[1] = sb_rd[0]; sb_rw[1] = sb_rw[0];
                sb_rd[0] = rd_e;     sb_rw[0] = reg_write_e;
            end
            if (m_ws) begin
                m_run++;
                if (TMO != 0 && m_run >= TMO) m_to = 1;
            end else begin
                m_run = 0;
            end
            m_ws = wc;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin cyc_begin(); eval(); tick(); end
    endtask

    initial begin
        int burst;
        idle();
        cyc_begin(); rst = 1; eval(); tick();
        chk_en = 1;
        cyc_begin(); rst = 1; rs1_e = 3; eval();
        chk("rst_flush_d", flush_d, 1);
        chk("rst_wait_st", wait_state, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_fwd_a", forward_a_e, 0);
        tick();

        // Load-use: one bubble, then W forwarding.
        idle_cycles(2);
        cyc_begin(); result_src_e = 1; reg_write_e = 1; rd_e = 5; rs1_d = 5; eval();
        chk("lu_stall_f", stall_f, 1);
        chk("lu_flush_e", flush_e, 1);
        chk("lu_flush_d", flush_d, 0);
        tick();
        cyc_begin(); eval(); chk("lu_bubble_stall", stall_f, 0); tick();
        cyc_begin(); rs1_e = 5; eval(); chk("lu_fwd_a", forward_a_e, FWD_W); tick();

        // ALU back-to-back.
        idle_cycles(2);
        cyc_begin(); reg_write_e = 1; rd_e = 3; eval(); chk("alu_stall", stall_f, 0); tick();
        cyc_begin(); rs2_e = 3; eval(); chk("alu_fwd_b", forward_b_e, FWD_M); tick();
        cyc_begin(); rs1_e = 3; eval(); chk("alu_fwd_a", forward_a_e, FWD_W); tick();

        // Branch with simultaneous load-use.
        cyc_begin(); pc_src_e = 1; result_src_e = 1; reg_write_e = 1; rd_e = 5; rs1_d = 5; eval();
        chk("br_flush_d", flush_d, 1);
        chk("br_flush_e", flush_e, 1);
        chk("br_stall_f", stall_f, 0);
        chk("br_stall_d", stall_d, 0);
        tick();

        // Memory wait of 3 cycles, scoreboard held, then advance.
        idle_cycles(2);
        for (int k = 0; k < 3; k++) begin
            cyc_begin(); mem_req_m = 1; reg_write_e = 1; rd_e = 7; rs1_e = 7; eval();
            chk("mw_freeze", freeze, 1);
            chk("mw_stall_d", stall_d, 1);
            chk("mw_wait_st", wait_state, (k == 0) ? 0 : 1);
            chk("mw_fwd_hold", forward_a_e, 0);
            tick();
        end
        cyc_begin(); mem_req_m = 1; mem_ready_m = 1; reg_write_e = 1; rd_e = 7; eval();
        chk("mw_ready_freeze", freeze, 0);
        chk("mw_ready_wait_st", wait_state, 1);
        tick();
        cyc_begin(); rs1_e = 7; eval();
        chk("mw_adv_fwd_a", forward_a_e, FWD_M);
        chk("mw_adv_wait_st", wait_state, 0);
        tick();

        // Timeout with TIMEOUT_CYCLES=4.
        idle_cycles(1);
        for (int k = 0; k < 6; k++) begin
            cyc_begin(); mem_req_m = 1; eval();
            if (k == 4) chk("to_before", mem_timeout, 0);
            if (k == 5) chk("to_set", mem_timeout, 1);
            tick();
        end
        cyc_begin(); mem_req_m = 1; mem_ready_m = 1; eval();
        chk("to_ready_freeze", freeze, 0);
        chk("to_sticky", mem_timeout, 1);
        tick();
        cyc_begin(); eval(); chk("to_sticky2", mem_timeout, 1); tick();
        cyc_begin(); rst = 1; eval(); tick();
        cyc_begin(); eval();
        chk("to_cleared", mem_timeout, 0);
        chk("to_run", wait_state, 0);
        tick();

        // Load to x0 never stalls.
        cyc_begin(); result_src_e = 1; reg_write_e = 1; rd_e = 0; rs1_d = 0; eval();
        chk("x0_stall_f", stall_f, 0);
        chk("x0_flush_e", flush_e, 0);
        tick();
`ifndef HAZARD_FWD_EN
        idle_cycles(2);
        for (int k = 0; k < 4; k++) begin
            cyc_begin(); rs1_d = 3;
            if (k == 0) begin reg_write_e = 1; rd_e = 3; end
            eval();
            chk("il_stall_f", stall_f, (k < 3) ? 1 : 0);
            tick();
        end
`endif

        // Randomized traffic.
        burst = 0;
        for (int n = 0; n < 800; n++) begin
            cyc_begin();
            rst          = ($urandom_range(0, 59) == 0);
            rs1_d        = 5'($urandom_range(0, 3));
            rs2_d        = 5'($urandom_range(0, 3));
            rs1_e        = 5'($urandom_range(0, 3));
            rs2_e        = 5'($urandom_range(0, 3));
            rd_e         = 5'($urandom_range(0, 3));
            reg_write_e  = $urandom_range(0, 1);
            result_src_e = ($urandom_range(0, 2) == 0);
            pc_src_e     = ($urandom_range(0, 6) == 0);
            if (burst == 0 && $urandom_range(0, 11) == 0) burst = $urandom_range(1, 7);
            if (burst > 0) begin
                mem_req_m = 1; mem_ready_m = 0; burst--;
            end else begin
                mem_req_m = $urandom_range(0, 1); mem_ready_m = ($urandom_range(0, 3) != 0);
            end
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
